// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package fetch_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory, redirect/stall and IF-stage signals of the fetch unit.
interface fetch_if;
  import fetch_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            instr_valid;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] instr_out;

  modport master (
    output imem_req_valid, imem_req_addr, instr_valid, pc_out, instr_out,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc, stall
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, instr_valid, pc_out, instr_out,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc, stall
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous flush and occupancy count.
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CW-1:0]    cnt_q;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    if (p == PW'(DEPTH-1)) return '0;
    return p + PW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= bump(wr_q);
      if (pop_i)  rd_q <= bump(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC generation, credit-limited imem requests, response
// buffering and redirect handling with stale-response dropping.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input logic      clk,
  input logic      rst,
  fetch_if.master  bus
);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [CW-1:0]   inflight, fifo_cnt, drop_q, drop_d;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] next_pc_q, next_pc_d, pc_hold_q, shadow_pc;
  logic            req_fire, rsp_fire, redirect, push, pop, valid;
  fetch_entry_t    head, rsp_entry;

  assign credit_used        = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign bus.imem_req_valid = !rst && (credit_used < (CW+1)'(DEPTH));
  assign bus.imem_req_addr  = next_pc_q;

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_fire = bus.imem_rsp_valid;
  assign redirect = bus.redirect_valid;
  assign valid    = (fifo_cnt != '0);
  assign pop      = valid && !bus.stall && !redirect;
  assign push     = rsp_fire && (drop_q == '0) && !redirect;

  // Never flushed: stale responses still retire their own shadow entries,
  // so its count is exactly the number of outstanding requests.
  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_shadow (
    .clk(clk), .rst(rst), .flush_i(1'b0),
    .push_i(req_fire), .data_i(next_pc_q),
    .pop_i(rsp_fire), .data_o(shadow_pc), .count_o(inflight)
  );

  assign rsp_entry = '{pc: shadow_pc, instr: bus.imem_rsp_data};

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_entries (
    .clk(clk), .rst(rst), .flush_i(redirect),
    .push_i(push), .data_i(rsp_entry),
    .pop_i(pop), .data_o(head), .count_o(fifo_cnt)
  );

  always_comb begin
    next_pc_d = next_pc_q;
    drop_d    = drop_q;
    if (redirect) begin
      next_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_d    = inflight + CW'(req_fire) - CW'(rsp_fire);
    end else begin
      if (req_fire) next_pc_d = next_pc_q + PC_INC;
      if (rsp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      next_pc_q <= RESET_PC;
      drop_q    <= '0;
      pc_hold_q <= '0;
    end else begin
      next_pc_q <= next_pc_d;
      drop_q    <= drop_d;
      if (valid) pc_hold_q <= head.pc;
    end
  end

  assign bus.instr_valid = valid;
  assign bus.pc_out      = valid ? head.pc : pc_hold_q;
  assign bus.instr_out   = valid ? head.instr : NOP_INSTR;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a latency-configurable in-order imem model.
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_if ifc();

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(ifc.master)
  );

  int n_cmp = 0;
  int n_err = 0;
  int consumed = 0;
  int cyc = 0;
  int lat = 1;
  fetch_entry_t exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Memory: fire recorded at negedge, answered in order lat cycles later.
  initial begin
    ifc.imem_rsp_valid = 1'b0;
    ifc.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (!rst && ifc.imem_req_valid && ifc.imem_req_ready) begin
        pend_addr.push_back(ifc.imem_req_addr);
        pend_due.push_back(cyc + lat);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        ifc.imem_rsp_valid = 1'b1;
        ifc.imem_rsp_data  = ~pend_addr[0];
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        ifc.imem_rsp_valid = 1'b0;
      end
    end
  end

  // Monitor: an instruction is consumed when presented, not stalled, not redirected.
  initial begin
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ifc.instr_valid && !ifc.stall && !ifc.redirect_valid) begin
          consumed++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_instr: got pc=%h instr=%h, expected none",
                     ifc.pc_out, ifc.instr_out);
          end else begin
            e = exp_q.pop_front();
            chk("stream_pc", ifc.pc_out, e.pc);
            chk("stream_instr", ifc.instr_out, e.instr);
          end
        end else if (!ifc.instr_valid) begin
          chk("idle_nop", ifc.instr_out, NOP_INSTR);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] p;
      p = start + 32'(4 * i);
      exp_q.push_back('{pc: p, instr: ~p});
    end
  endtask

  task automatic run_stream(input logic [31:0] start, input int n, input bit thr);
    int target;
    bit done;
    push_exp(start, n);
    target = consumed + n;
    done = 1'b0;
    ifc.stall = 1'b0;
    for (int k = 0; k < 40 * n + 50; k++) begin
      tick();
      ifc.imem_req_ready = thr ? ((cyc % 3) != 0) : 1'b1;
      if (consumed >= target) begin
        ifc.stall = 1'b1;
        done = 1'b1;
        break;
      end
    end
    ifc.stall = 1'b1;
    ifc.imem_req_ready = 1'b1;
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL stream_timeout: got %0d consumed, expected %0d", consumed, target);
    end
  endtask

  task automatic do_redirect(input logic [31:0] addr);
    logic [31:0] aligned;
    aligned = {addr[31:2], 2'b00};
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc    = addr;
    exp_q.delete();
    tick();
    ifc.redirect_valid = 1'b0;
    chk("redir_addr", ifc.imem_req_addr, aligned);
    chk("redir_valid_low", 32'(ifc.instr_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    bit hit;
    ifc.imem_req_ready = 1'b1;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc    = '0;
    ifc.stall          = 1'b1;

    #3;
    chk("rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    chk("rst_req_addr", ifc.imem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
    chk("rst_pc_out", ifc.pc_out, 32'h0);
    chk("rst_instr_out", ifc.instr_out, NOP_INSTR);
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("first_req_addr", ifc.imem_req_addr, 32'h0);
    chk("first_req_valid", 32'(ifc.imem_req_valid), 32'd1);

    run_stream(32'h0, 8, 1'b0);

    // Stall with the FIFO allowed to fill up
    repeat (3) tick();
    for (int k = 0; k < 5; k++) begin
      chk("stall_head_pc", ifc.pc_out, 32'h20);
      chk("stall_valid", 32'(ifc.instr_valid), 32'd1);
      chk("stall_no_req", 32'(ifc.imem_req_valid), 32'd0);
      tick();
    end
    run_stream(32'h20, 6, 1'b1);

    // Redirect with two requests outstanding
    lat = 3;
    push_exp(32'h38, 16);
    ifc.stall = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (pend_addr.size() == 2) begin
        hit = 1'b1;
        break;
      end
    end
    chk("two_inflight_seen", 32'(hit), 32'd1);
    do_redirect(32'h0000_0103);
    run_stream(32'h100, 5, 1'b0);

    // Redirect coinciding with request fire and response fire
    lat = 1;
    push_exp(32'h114, 16);
    ifc.stall = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (ifc.imem_req_valid && ifc.imem_req_ready && ifc.imem_rsp_valid) begin
        hit = 1'b1;
        break;
      end
    end
    chk("coincide_seen", 32'(hit), 32'd1);
    do_redirect(32'h0000_0200);
    run_stream(32'h200, 5, 1'b0);

    // Address wrap past 0xFFFF_FFFC
    do_redirect(32'hFFFF_FFF8);
    run_stream(32'hFFFF_FFF8, 5, 1'b0);

    // Asynchronous reset with the FIFO non-empty
    tick();
    tick();
    chk("pre_rst_valid", 32'(ifc.instr_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_instr_valid", 32'(ifc.instr_valid), 32'd0);
    chk("async_rst_req_valid", 32'(ifc.imem_req_valid), 32'd0);
    chk("async_rst_addr", ifc.imem_req_addr, 32'h0);
    exp_q.delete();
    pend_addr.delete();
    pend_due.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("restart_addr", ifc.imem_req_addr, 32'h0);
    run_stream(32'h0, 6, 1'b0);

    repeat (3) tick();
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
